sequential_multiplier: RTL

Sequential 16×16 shift-add multiplier for the NEANDER-X CPU datapath, the companion to the sequential divider and sharing its start/busy/done handshake. It serves the MUL instruction path, produces a 32-bit product split into high and low words, and supports unsigned and two's-complement signed operands. It trades a single-cycle array multiplier for a fixed 18-cycle latency to save area on the TinyTapeout tile.

---
 rtl/sequential_multiplier.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sequential_multiplier.sv
// 16x16 shift-add multiplier, one partial product per cycle, fixed 18-cycle latency.
// Signed operands are handled as magnitudes with a final two's-complement fixup.
module sequential_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  input  logic        signed_mode,
  output logic [15:0] product_lo,
  output logic [15:0] product_hi,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FIXUP  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic        sgn_q, sgn_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        ovf_q, ovf_d;

  logic [15:0] absA, absB;
  logic [16:0] sum;
  logic [32:0] shifted;
  logic [31:0] magnitude;
  logic [31:0] prod;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
    end
  end

  // 0x8000 negates to itself, which is exactly its unsigned magnitude.
  assign absA      = (signed_mode && multiplicand[15]) ? (~multiplicand + 16'd1) : multiplicand;
  assign absB      = (signed_mode && multiplier[15])   ? (~multiplier + 16'd1)   : multiplier;
  assign sum       = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
  assign shifted   = {sum, mplier_q} >> 1;
  assign magnitude = {acc_q[15:0], mplier_q};
  assign prod      = neg_q ? (~magnitude + 32'd1) : magnitude;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MULT;
          mcand_d  = absA;
          mplier_d = absB;
          neg_d    = signed_mode & (multiplicand[15] ^ multiplier[15]);
          sgn_d    = signed_mode;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      MULT: begin
        acc_d    = shifted[32:16];
        mplier_d = shifted[15:0];
        count_d  = count_q + 4'd1;
        if (count_q == 4'd15) state_d = FIXUP;
      end
      FIXUP: begin
        hi_d    = prod[31:16];
        lo_d    = prod[15:0];
        ovf_d   = sgn_q ? (prod[31:16] != {16{prod[15]}}) : (prod[31:16] != 16'd0);
        state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == MULT) || (state_q == FIXUP);
  assign done       = (state_q == FINISH);

endmodule
